// File: rtl/spi_mem_responder_pkg.sv
// Shared definitions for the SPI NOR-flash responder: opcodes, status bit positions,
// FSM state encoding and the helper that picks the bits driven onto DQ.
package spi_mem_responder_pkg;

    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_BE   = 8'hC7;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DOUT, ST_DIN, ST_SINK
    } state_t;

    typedef enum logic [2:0] {
        CK_NONE, CK_RDSR, CK_RDID, CK_READ, CK_PP, CK_BE
    } cmd_kind_t;

    // Bits of byte b starting at bit position pos (0 = MSB) placed on the DQ lanes:
    // quad uses DQ[3:0], single uses DQ1 only.
    function automatic logic [3:0] lane_bits(input logic [7:0] b, input logic [2:0] pos,
                                             input logic quad);
        logic [7:0] s;
        s = b << pos;
        return quad ? s[7:4] : {2'b00, s[7], 1'b0};
    endfunction

endpackage

// File: rtl/spi_mem_responder_array.sv
// Byte array behind the SPI responder: combinational read, AND-write, and a bulk-erase
// sequencer that writes 8'hFF to one location per cycle while wip is high.
module spi_mem_responder_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_dat,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_dat,
    input  logic          erase_start,
    output logic          wip,
    output logic          erase_last
);

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] ecnt_q, ecnt_d;
    logic          wip_q, wip_d;

    assign rd_dat     = mem[rd_addr];
    assign wip        = wip_q;
    assign erase_last = wip_q && (ecnt_q == {AW{1'b1}});

    always_comb begin
        ecnt_d = ecnt_q;
        wip_d  = wip_q;
        if (wip_q) begin
            ecnt_d = ecnt_q + AW'(1);
            if (erase_last) wip_d = 1'b0;
        end else if (erase_start) begin
            wip_d  = 1'b1;
            ecnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt_q <= '0;
            wip_q  <= 1'b0;
        end else begin
            ecnt_q <= ecnt_d;
            wip_q  <= wip_d;
        end
    end

    // Contents survive reset; the erase sequencer owns the write port while running.
    always_ff @(posedge clk) begin
        if (wip_q) mem[ecnt_q] <= 8'hFF;
        else if (wr_en) mem[wr_addr] <= mem[wr_addr] & wr_dat;
    end

endmodule

// File: rtl/spi_mem_responder.sv
// SPI NOR-flash target sharing the master's clock; decodes RDSR/RDID/WREN/WRDI/READ/PP/BE
// in single or quad mode with zero-turnaround output over DQio.
module spi_mem_responder
    import spi_mem_responder_pkg::*;
#(
    parameter int         MEM_AW   = 12,
    parameter logic [7:0] JEDEC_ID = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       quad_mode,
    input  logic       S,
    inout  wire  [3:0] DQio,
    output logic       wip,
    output logic       wel,
    output logic [7:0] last_cmd
);

    state_t            state_q, state_d;
    cmd_kind_t         cmd_q, cmd_d;
    logic [4:0]        cnt_q, cnt_d, cnt_inc, bpc;
    logic [23:0]       sr_q, sr_d, sr_shift;
    logic [MEM_AW-1:0] addr_q, addr_d, rd_addr;
    logic [7:0]        out_byte_q, out_byte_d, new_byte, status, rd_dat;
    logic [3:0]        dq_out_q, dq_out_d, dq_oe_q, dq_oe_d, lane_oe, dq_in;
    logic              wel_q, wel_d;
    logic [7:0]        last_cmd_q, last_cmd_d;
    logic              wr_en, erase_start, erase_last, load_byte;

    assign dq_in    = DQio;
    assign bpc      = quad_mode ? 5'd4 : 5'd1;
    assign cnt_inc  = cnt_q + bpc;
    assign sr_shift = quad_mode ? {sr_q[19:0], dq_in} : {sr_q[22:0], dq_in[0]};
    assign lane_oe  = quad_mode ? 4'hF : 4'b0010;
    // The first READ byte is addressed by the address bits arriving on this very edge.
    assign rd_addr  = (state_q == ST_ADDR) ? sr_shift[MEM_AW-1:0] : addr_q;

    for (genvar i = 0; i < 4; i++) begin : g_dq
        assign DQio[i] = dq_oe_q[i] ? dq_out_q[i] : 1'bz;
    end

    spi_mem_responder_array #(.AW(MEM_AW)) u_array (
        .clk         (clk),
        .rst_n       (reset),
        .rd_addr     (rd_addr),
        .rd_dat      (rd_dat),
        .wr_en       (wr_en),
        .wr_addr     (addr_q),
        .wr_dat      (sr_shift[7:0]),
        .erase_start (erase_start),
        .wip         (wip),
        .erase_last  (erase_last)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        addr_d      = addr_q;
        out_byte_d  = out_byte_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        wel_d       = wel_q;
        last_cmd_d  = last_cmd_q;
        wr_en       = 1'b0;
        erase_start = 1'b0;
        load_byte   = 1'b0;
        new_byte    = 8'h00;
        status          = 8'h00;
        status[SR_WEL]  = wel_q;
        status[SR_WIP]  = wip;

        if (erase_last) wel_d = 1'b0;

        if (S) begin
            // Output stays up through the deselect edge and drops on the one after.
            state_d = ST_IDLE;
            cmd_d   = CK_NONE;
            cnt_d   = '0;
            if (state_q == ST_IDLE) dq_oe_d = 4'h0;
            if (cmd_q == CK_PP) wel_d = 1'b0;
            if (cmd_q == CK_BE) erase_start = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_CMD: begin
                    dq_oe_d = 4'h0;
                    sr_d    = sr_shift;
                    cnt_d   = cnt_inc;
                    state_d = ST_CMD;
                    if (cnt_inc == 5'd8) begin
                        cnt_d      = '0;
                        state_d    = ST_SINK;
                        last_cmd_d = sr_shift[7:0];
                        if (!wip || sr_shift[7:0] == OP_RDSR) begin
                            case (sr_shift[7:0])
                                OP_RDSR: begin
                                    state_d = ST_DOUT; cmd_d = CK_RDSR;
                                    new_byte = status; load_byte = 1'b1;
                                end
                                OP_RDID: begin
                                    state_d = ST_DOUT; cmd_d = CK_RDID;
                                    new_byte = JEDEC_ID; load_byte = 1'b1;
                                end
                                OP_WREN: wel_d = 1'b1;
                                OP_WRDI: wel_d = 1'b0;
                                OP_READ: begin
                                    state_d = ST_ADDR; cmd_d = CK_READ;
                                    last_cmd_d = last_cmd_q;
                                end
                                OP_PP: if (wel_q) begin
                                    state_d = ST_ADDR; cmd_d = CK_PP;
                                    last_cmd_d = last_cmd_q;
                                end
                                OP_BE: if (wel_q) cmd_d = CK_BE;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_inc;
                    if (cnt_inc == 5'd24) begin
                        cnt_d = '0;
                        if (cmd_q == CK_READ) begin
                            state_d    = ST_DOUT;
                            last_cmd_d = OP_READ;
                            new_byte   = rd_dat;
                            load_byte  = 1'b1;
                            addr_d     = sr_shift[MEM_AW-1:0] + MEM_AW'(1);
                        end else begin
                            state_d    = ST_DIN;
                            last_cmd_d = OP_PP;
                            addr_d     = sr_shift[MEM_AW-1:0];
                        end
                    end
                end
                ST_DOUT: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 5'd8) begin
                        cnt_d     = '0;
                        load_byte = 1'b1;
                        case (cmd_q)
                            CK_RDSR: new_byte = status;
                            CK_RDID: new_byte = JEDEC_ID;
                            default: begin
                                new_byte = rd_dat;
                                addr_d   = addr_q + MEM_AW'(1);
                            end
                        endcase
                    end else begin
                        dq_out_d = lane_bits(out_byte_q, cnt_inc[2:0], quad_mode);
                    end
                end
                ST_DIN: begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_inc;
                    if (cnt_inc == 5'd8) begin
                        // Page program wraps inside the current 256-byte page.
                        cnt_d  = '0;
                        wr_en  = 1'b1;
                        addr_d = {addr_q[MEM_AW-1:8], addr_q[7:0] + 8'd1};
                    end
                end
                default: ;
            endcase
        end

        if (load_byte) begin
            out_byte_d = new_byte;
            dq_out_d   = lane_bits(new_byte, 3'd0, quad_mode);
            dq_oe_d    = lane_oe;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CK_NONE;
            cnt_q      <= '0;
            sr_q       <= '0;
            addr_q     <= '0;
            out_byte_q <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= '0;
            wel_q      <= 1'b0;
            last_cmd_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            addr_q     <= addr_d;
            out_byte_q <= out_byte_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            wel_q      <= wel_d;
            last_cmd_q <= last_cmd_d;
        end
    end

    assign wel      = wel_q;
    assign last_cmd = last_cmd_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: an SPI-master driver with a flash reference model feeding
// an expected-byte queue, and a negedge monitor that assembles DQ output and compares.
module tb_spi_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       quad = 1'b0;
    logic       S = 1'b1;
    logic [3:0] tb_dq = 4'h0;
    logic [3:0] tb_en = 4'h0;
    wire  [3:0] dq;
    logic       wip, wel;
    logic [7:0] last_cmd;

    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign dq[i] = tb_en[i] ? tb_dq[i] : 1'bz;
    end

    always #5 clk = ~clk;

    spi_mem_responder #(.MEM_AW(12), .JEDEC_ID(8'h20)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .quad_mode (quad),
        .S         (S),
        .DQio      (dq),
        .wip       (wip),
        .wel       (wel),
        .last_cmd  (last_cmd)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem_m [4096];
    logic       wel_m = 1'b0;
    logic       wip_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: behaves as the master sampling DQ at the next edge while S is low.
    logic [7:0] acc;
    int         acc_n = 0;
    logic [7:0] e_m;
    always @(negedge clk) begin
        if (!rst_n || S) begin
            acc_n = 0;
        end else if (dut.dq_oe_q != 4'h0) begin
            if (quad) begin acc = {acc[3:0], dq}; acc_n += 4; end
            else begin acc = {acc[6:0], dq[1]}; acc_n += 1; end
            if (acc_n == 8) begin
                acc_n = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got %02h want none", acc);
                end else begin
                    e_m = exp_q.pop_front();
                    if (acc !== e_m) begin
                        errors++;
                        $display("FAIL dout_byte got %02h want %02h", acc, e_m);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] v, input int nbits);
        S = 1'b0;
        tb_en = quad ? 4'hF : 4'b1101;
        for (int i = nbits; i > 0; i -= (quad ? 4 : 1)) begin
            if (quad) tb_dq = v[i-1 -: 4];
            else tb_dq = {2'b11, 1'b0, v[i-1]};
            tick();
        end
    endtask

    task automatic finish_cmd();
        S = 1'b1;
        tb_en = 4'h0;
        tick();
        tick();
    endtask

    function automatic logic [3:0] lanes();
        return wip_m ? 4'h0 : (quad ? 4'hF : 4'b0010);
    endfunction

    task automatic clock_bytes(input int n);
        tb_en = quad ? 4'h0 : 4'b1101;
        tb_dq = 4'b1100;
        for (int i = 0; i < n * (quad ? 2 : 8); i++) tick();
    endtask

    task automatic do_status(input logic [7:0] op, input int n);
        send({24'h0, op}, 8);
        chk("oe_after_header", {28'h0, dut.dq_oe_q}, {28'h0, quad ? 4'hF : 4'b0010});
        for (int i = 0; i < n; i++)
            exp_q.push_back(op == 8'h9F ? 8'h20 : {6'b0, wel_m, wip_m});
        clock_bytes(n);
        finish_cmd();
        chk("last_cmd", {24'h0, last_cmd}, {24'h0, op});
    endtask

    task automatic do_read(input logic [11:0] a, input int n);
        send({8'h03, 12'h000, a}, 32);
        chk("oe_after_read_hdr", {28'h0, dut.dq_oe_q}, {28'h0, lanes()});
        if (!wip_m)
            for (int i = 0; i < n; i++) exp_q.push_back(mem_m[12'(a + i)]);
        clock_bytes(n);
        finish_cmd();
        chk("oe_released", {28'h0, dut.dq_oe_q}, 32'h0);
    endtask

    task automatic do_simple(input logic [7:0] op);
        send({24'h0, op}, 8);
        finish_cmd();
        if (!wip_m && op == 8'h06) wel_m = 1'b1;
        if (!wip_m && op == 8'h04) wel_m = 1'b0;
        chk("wel_after_cmd", {31'h0, wel}, {31'h0, wel_m});
    endtask

    task automatic do_pp(input logic [11:0] a, input logic [31:0] d, input int n);
        send({8'h02, 12'h000, a}, 32);
        for (int j = 0; j < n; j++) begin
            send({24'h0, d[8*j +: 8]}, 8);
            if (wel_m && !wip_m)
                mem_m[{a[11:8], 8'(a[7:0] + j)}] &= d[8*j +: 8];
        end
        finish_cmd();
        if (!wip_m) wel_m = 1'b0;
        chk("wel_after_pp", {31'h0, wel}, {31'h0, wel_m});
    endtask

    int wip_cycles;
    int kind;

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_oe", {28'h0, dut.dq_oe_q}, 32'h0);
        chk("rst_wip", {31'h0, wip}, 32'h0);
        chk("rst_wel", {31'h0, wel}, 32'h0);
        chk("rst_last_cmd", {24'h0, last_cmd}, 32'h0);

        do_status(8'h05, 2);
        do_simple(8'h06);
        do_status(8'h05, 1);

        // BE with wel = 0 must not start an erase.
        do_simple(8'h04);
        send(32'hC7, 8);
        finish_cmd();
        chk("be_without_wren", {31'h0, wip}, 32'h0);

        // Bulk erase with status polling and a READ attempt while busy.
        do_simple(8'h06);
        send(32'hC7, 8);
        S = 1'b1;
        tb_en = 4'h0;
        wip_cycles = 0;
        fork
            begin
                for (int t = 0; t < 6000; t++) begin
                    tick();
                    if (wip) wip_cycles++;
                    else if (wip_cycles > 0) break;
                end
            end
            begin
                tick(); tick();
                wip_m = 1'b1;
                do_status(8'h05, 2);
                do_read(12'h010, 2);
                quad = 1'b1;
                do_status(8'h05, 1);
                quad = 1'b0;
            end
        join
        chk("wip_cycles", wip_cycles, 4096);
        wip_m = 1'b0;
        wel_m = 1'b0;
        for (int i = 0; i < 4096; i++) mem_m[i] = 8'hFF;
        chk("wel_after_erase", {31'h0, wel}, 32'h0);
        do_status(8'h05, 1);
        quad = 1'b1;
        do_read(12'hFF8, 16);
        quad = 1'b0;

        // Page program with page wrap, then readback across the page boundary.
        do_simple(8'h06);
        do_pp(12'h0FE, 32'h000F3CA5, 3);
        do_read(12'h0FE, 3);
        do_read(12'h000, 1);
        quad = 1'b1;
        do_read(12'h0FF, 1);
        quad = 1'b0;

        do_pp(12'h010, 32'h0, 1);
        do_read(12'h010, 1);

        do_status(8'h9F, 2);
        quad = 1'b1;
        do_status(8'h9F, 1);
        quad = 1'b0;

        // Deselect after 5 opcode bits of WREN: nothing happens.
        send(32'h00, 5);
        finish_cmd();
        chk("partial_opcode_wel", {31'h0, wel}, 32'h0);
        chk("partial_opcode_last", {24'h0, last_cmd}, 32'h9F);

        // Reset mid-READ output: DQ released immediately.
        send({8'h03, 24'h000100}, 32);
        exp_q.push_back(mem_m[12'h100]);
        clock_bytes(1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("async_reset_oe", {28'h0, dut.dq_oe_q}, 32'h0);
        S = 1'b1; tb_en = 4'h0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during a PP data byte: byte untouched, wel cleared.
        do_simple(8'h06);
        send({8'h02, 24'h000020}, 32);
        send(32'h0, 4);
        rst_n = 1'b0;
        #1;
        wel_m = 1'b0;
        chk("reset_pp_wel", {31'h0, wel}, 32'h0);
        chk("reset_pp_oe", {28'h0, dut.dq_oe_q}, 32'h0);
        S = 1'b1; tb_en = 4'h0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_last_cmd", {24'h0, last_cmd}, 32'h0);
        do_read(12'h020, 1);

        for (int it = 0; it < 80; it++) begin
            quad = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 7);
            case (kind)
                0: do_status(8'h05, $urandom_range(1, 3));
                1: do_status(8'h9F, $urandom_range(1, 2));
                2, 3: do_simple(8'h06);
                4: do_simple(8'h04);
                5: do_read(12'($urandom_range(12'h0F0, 12'h11F)), $urandom_range(1, 4));
                6: do_pp(12'($urandom_range(12'h0F0, 12'h11F)), $urandom, $urandom_range(1, 4));
                default: begin
                    send({24'h0, 8'hAB}, 8);
                    send({24'h0, 8'(($urandom))}, 8);
                    finish_cmd();
                    chk("sink_last_cmd", {24'h0, last_cmd}, 32'hAB);
                end
            endcase
        end

        chk("expected_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
